// File: rtl/mem_access_unit.sv
// SPARC load/store sequencer: decodes op3, checks alignment, runs one or two
// word beats on a valid/ack memory port and returns extended load data or a trap.
module mem_access_unit #(
   parameter int ADDR_W    = 32,
   parameter bit ENABLE_DW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [5:0]        op3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              rsp_valid,
   output logic [63:0]       rsp_data,
   output logic [1:0]        rsp_trap
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

   typedef struct packed {
      logic  legal;
      logic  store;
      logic  sgn;
      size_t size;
   } dec_t;

   localparam logic [1:0] TRAP_ALIGN   = 2'b01;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b10;

   function automatic dec_t decode_op(input logic [5:0] op);
      dec_t d;
      d.legal = 1'b1;
      d.store = 1'b0;
      d.sgn   = 1'b0;
      d.size  = SZ_W;
      case (op)
         6'b001001: begin d.sgn = 1'b1; d.size = SZ_B; end
         6'b001010: begin d.sgn = 1'b1; d.size = SZ_H; end
         6'b000001: d.size = SZ_B;
         6'b000010: d.size = SZ_H;
         6'b000000: d.size = SZ_W;
         6'b000011: begin d.size = SZ_D; d.legal = ENABLE_DW; end
         6'b000101: begin d.store = 1'b1; d.size = SZ_B; end
         6'b000110: begin d.store = 1'b1; d.size = SZ_H; end
         6'b000100: begin d.store = 1'b1; d.size = SZ_W; end
         6'b000111: begin d.store = 1'b1; d.size = SZ_D; d.legal = ENABLE_DW; end
         default:   d.legal = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic misaligned(input size_t sz, input logic [2:0] a);
      case (sz)
         SZ_H:    return a[0];
         SZ_W:    return (a[1:0] != 2'b00);
         SZ_D:    return (a != 3'b000);
         default: return 1'b0;
      endcase
   endfunction

   // Big-endian lanes: byte offset 0 lives in bits 31:24 (be[3]).
   function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] a);
      case (sz)
         SZ_B: begin
            case (a)
               2'b00:   return 4'b1000;
               2'b01:   return 4'b0100;
               2'b10:   return 4'b0010;
               default: return 4'b0001;
            endcase
         end
         SZ_H:    return a[1] ? 4'b0011 : 4'b1100;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input size_t sz, input logic [63:0] wd);
      case (sz)
         SZ_B:    return {4{wd[7:0]}};
         SZ_H:    return {2{wd[15:0]}};
         SZ_D:    return wd[63:32];
         default: return wd[31:0];
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input size_t sz, input logic sgn,
                                                input logic [1:0] a, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'b00:   b = rd[31:24];
         2'b01:   b = rd[23:16];
         2'b10:   b = rd[15:8];
         default: b = rd[7:0];
      endcase
      h = a[1] ? rd[15:0] : rd[31:16];
      case (sz)
         SZ_B:    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
         SZ_H:    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: return rd;
      endcase
   endfunction

   state_t      state;
   dec_t        dec_in;
   size_t       size_q;
   logic        sgn_q;
   logic        store_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] wdata_lo_q;
   logic [31:0] rdata_hi_q;

   assign dec_in = decode_op(op3);

   // Request context and first LDD word; no reset needed, only read after capture.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         size_q     <= dec_in.size;
         sgn_q      <= dec_in.sgn;
         store_q    <= dec_in.store;
         addr_lo_q  <= addr[1:0];
         wdata_lo_q <= wdata[31:0];
      end
      if (state == ACC0 && mem_ack) begin
         rdata_hi_q <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_data  <= 64'h0;
         rsp_trap  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (!dec_in.legal) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_trap  <= TRAP_ILLEGAL;
                  end else if (misaligned(dec_in.size, addr[2:0])) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_trap  <= TRAP_ALIGN;
                  end else begin
                     state     <= ACC0;
                     mem_en    <= 1'b1;
                     mem_we    <= dec_in.store;
                     mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= lane_be(dec_in.size, addr[1:0]);
                     mem_wdata <= dec_in.store ? store_lanes(dec_in.size, wdata) : 32'h0;
                  end
               end
            end
            ACC0: begin
               if (mem_ack) begin
                  if (size_q == SZ_D) begin
                     state     <= ACC1;
                     mem_addr  <= mem_addr + ADDR_W'(4);
                     mem_wdata <= store_q ? wdata_lo_q : 32'h0;
                  end else begin
                     state     <= RESP;
                     mem_en    <= 1'b0;
                     mem_we    <= 1'b0;
                     mem_addr  <= '0;
                     mem_be    <= 4'b0000;
                     mem_wdata <= 32'h0;
                     rsp_valid <= 1'b1;
                     rsp_data  <= store_q ? 64'h0
                                          : {32'h0, load_extract(size_q, sgn_q, addr_lo_q, mem_rdata)};
                  end
               end
            end
            ACC1: begin
               if (mem_ack) begin
                  state     <= RESP;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= 4'b0000;
                  mem_wdata <= 32'h0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= store_q ? 64'h0 : {rdata_hi_q, mem_rdata};
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_data  <= 64'h0;
               rsp_trap  <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of expected beats and responses,
// checked every cycle against two instances (doubleword support on and off).
module tb_mem_access_unit;

   typedef struct packed {
      logic [1:0]       trap;
      logic [1:0]       nb;
      logic             we;
      logic [1:0][31:0] baddr;
      logic [1:0][3:0]  be;
      logic [1:0][31:0] wd;
      logic [63:0]      data;
      logic [7:0]       lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [5:0]  op3;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        req_ready, mem_en, mem_we, rsp_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_trap;

   logic        req_ready_n, mem_en_n, mem_we_n, rsp_valid_n;
   logic [31:0] mem_addr_n, mem_wdata_n;
   logic [3:0]  mem_be_n;
   logic [63:0] rsp_data_n;
   logic [1:0]  rsp_trap_n;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rsp_cyc0 = 0;
   int   rsp_cyc1 = 0;
   int   bidx0 = 0;
   int   bidx1 = 0;
   int   rsp_cnt = 0;
   bit   chk_en = 1'b0;
   bit   have_req = 1'b0;
   bit   win0, win1, en0, en1;
   exp_t e0, e1, pin;

   mem_access_unit #(.ADDR_W(32), .ENABLE_DW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .op3(op3), .addr(addr), .wdata(wdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_trap(rsp_trap)
   );

   mem_access_unit #(.ADDR_W(32), .ENABLE_DW(1'b0)) dut_nodw (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_n),
      .op3(op3), .addr(addr), .wdata(wdata),
      .mem_en(mem_en_n), .mem_we(mem_we_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
      .mem_wdata(mem_wdata_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rsp_valid(rsp_valid_n), .rsp_data(rsp_data_n), .rsp_trap(rsp_trap_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // What a request must produce, from the op3 table, lane rules and beat/wait counts.
   function automatic exp_t model(input logic [5:0] o, input logic [31:0] a, input logic [63:0] wd,
                                  input logic [31:0] rd0, input logic [31:0] rd1,
                                  input int w0, input int w1, input bit dw);
      exp_t   e;
      int     size, off, sh;
      bit     st, sg, ok;
      longint v;
      e = '0; size = 4; st = 1'b0; sg = 1'b0; ok = 1'b1;
      case (o)
         6'b001001: begin size = 1; sg = 1'b1; end
         6'b001010: begin size = 2; sg = 1'b1; end
         6'b000001: size = 1;
         6'b000010: size = 2;
         6'b000000: size = 4;
         6'b000011: begin size = 8; ok = dw; end
         6'b000101: begin size = 1; st = 1'b1; end
         6'b000110: begin size = 2; st = 1'b1; end
         6'b000100: begin size = 4; st = 1'b1; end
         6'b000111: begin size = 8; st = 1'b1; ok = dw; end
         default:   ok = 1'b0;
      endcase
      off = int'(a[1:0]);
      if (!ok) begin
         e.trap = 2'b10; e.lat = 8'd1;
         return e;
      end
      if ((int'(a[3:0]) % size) != 0) begin
         e.trap = 2'b01; e.lat = 8'd1;
         return e;
      end
      e.nb = (size == 8) ? 2'd2 : 2'd1;
      e.we = st;
      e.baddr[0] = a - 32'(off);
      e.baddr[1] = a - 32'(off) + 32'd4;
      e.be[0] = (size == 1) ? (4'b1000 >> off) : (size == 2) ? (4'b1100 >> off) : 4'b1111;
      e.be[1] = 4'b1111;
      if (st) begin
         if (size == 1)      e.wd[0] = {4{wd[7:0]}};
         else if (size == 2) e.wd[0] = {2{wd[15:0]}};
         else if (size == 4) e.wd[0] = wd[31:0];
         else begin e.wd[0] = wd[63:32]; e.wd[1] = wd[31:0]; end
      end else if (size <= 2) begin
         sh = 8 * (4 - size - off);
         v = longint'((rd0 >> sh) & ((32'd1 << (8 * size)) - 32'd1));
         if (sg && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
         e.data = {32'h0, 32'(v)};
      end else if (size == 4) begin
         e.data = {32'h0, rd0};
      end else begin
         e.data = {rd0, rd1};
      end
      e.lat = 8'(int'(e.nb) + w0 + ((size == 8) ? w1 : 0) + 1);
      return e;
   endfunction

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (chk_en) begin
         win0 = have_req && cyc > acc_cyc && cyc <= rsp_cyc0;
         win1 = have_req && cyc > acc_cyc && cyc <= rsp_cyc1;
         chk("d0_req_ready", req_ready, !win0);
         chk("d0_rsp_valid", rsp_valid, have_req && cyc == rsp_cyc0);
         if (rsp_valid) begin
            rsp_cnt++;
            chk("d0_rsp_data", rsp_data, e0.data);
            chk("d0_rsp_trap", rsp_trap, e0.trap);
         end else begin
            chk("d0_idle_rsp_data", rsp_data, 64'h0);
            chk("d0_idle_rsp_trap", rsp_trap, 2'b00);
         end
         en0 = have_req && e0.nb != 2'd0 && cyc > acc_cyc && cyc < rsp_cyc0;
         chk("d0_mem_en", mem_en, en0);
         if (mem_en && en0 && bidx0 < 2) begin
            chk("d0_mem_addr", mem_addr, e0.baddr[bidx0]);
            chk("d0_mem_be", mem_be, e0.be[bidx0]);
            chk("d0_mem_we", mem_we, e0.we);
            if (e0.we) chk("d0_mem_wdata", mem_wdata, e0.wd[bidx0]);
            if (mem_ack) bidx0++;
         end
         chk("d1_req_ready", req_ready_n, !win1);
         chk("d1_rsp_valid", rsp_valid_n, have_req && cyc == rsp_cyc1);
         if (rsp_valid_n) begin
            chk("d1_rsp_data", rsp_data_n, e1.data);
            chk("d1_rsp_trap", rsp_trap_n, e1.trap);
         end else begin
            chk("d1_idle_rsp_trap", rsp_trap_n, 2'b00);
         end
         en1 = have_req && e1.nb != 2'd0 && cyc > acc_cyc && cyc < rsp_cyc1;
         chk("d1_mem_en", mem_en_n, en1);
         if (mem_en_n && en1 && bidx1 < 2) begin
            chk("d1_mem_addr", mem_addr_n, e1.baddr[bidx1]);
            chk("d1_mem_be", mem_be_n, e1.be[bidx1]);
            chk("d1_mem_we", mem_we_n, e1.we);
            if (e1.we) chk("d1_mem_wdata", mem_wdata_n, e1.wd[bidx1]);
            if (mem_ack) bidx1++;
         end
      end
   end

   // Called at posedge+1 with both instances idle; a stray request is driven while busy.
   task automatic do_req(input logic [5:0] o, input logic [31:0] a, input logic [63:0] wd,
                         input logic [31:0] rd0, input logic [31:0] rd1, input int w0, input int w1);
      int start;
      int nb;
      e0 = model(o, a, wd, rd0, rd1, w0, w1, 1'b1);
      e1 = model(o, a, wd, rd0, rd1, w0, w1, 1'b0);
      op3 = o; addr = a; wdata = wd; req_valid = 1'b1;
      acc_cyc  = cyc + 1;
      rsp_cyc0 = acc_cyc + int'(e0.lat);
      rsp_cyc1 = acc_cyc + int'(e1.lat);
      bidx0 = 0; bidx1 = 0; have_req = 1'b1;
      start = rsp_cnt;
      nb = int'(e0.nb);
      @(posedge clk); #1;
      op3 = 6'b111111; addr = 32'h1;
      for (int b = 0; b < nb; b++) begin
         for (int w = 0; w < ((b == 0) ? w0 : w1); w++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
         mem_ack = 1'b1;
         mem_rdata = (b == 0) ? rd0 : rd1;
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF; req_valid = 1'b0;
      end
      for (int t = 0; t < 40 && rsp_cnt == start; t++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
      req_valid = 1'b0;
      if (rsp_cnt == start) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout: got no rsp_valid, want one for op3 %b addr %h", o, a);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; op3 = 6'h0; addr = 32'h0; wdata = 64'h0;
      mem_rdata = 32'h0; mem_ack = 1'b0;
      #12;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", mem_be, 4'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_rsp_trap", rsp_trap, 2'b00);
      chk("rst_nodw_req_ready", req_ready_n, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      pin = model(6'b001001, 32'h103, 64'h0, 32'h000000F0, 32'h0, 0, 0, 1'b1);
      chk("pin_ldsb_data", pin.data, 64'h00000000_FFFFFFF0);
      chk("pin_ldsb_be", pin.be[0], 4'b0001);
      chk("pin_ldsb_lat", pin.lat, 8'd2);
      pin = model(6'b000010, 32'h200, 64'h0, 32'h80011234, 32'h0, 2, 0, 1'b1);
      chk("pin_lduh_data", pin.data, 64'h00008001);
      chk("pin_lduh_lat", pin.lat, 8'd4);
      pin = model(6'b000111, 32'h308, 64'h11111111_22222222, 32'h0, 32'h0, 0, 0, 1'b1);
      chk("pin_std_addr1", pin.baddr[1], 32'h30C);
      chk("pin_std_wd0", pin.wd[0], 32'h11111111);
      chk("pin_std_wd1", pin.wd[1], 32'h22222222);
      chk("pin_std_lat", pin.lat, 8'd3);
      pin = model(6'b000000, 32'h102, 64'h0, 32'h0, 32'h0, 0, 0, 1'b1);
      chk("pin_ld_misalign", pin.trap, 2'b01);
      pin = model(6'b111111, 32'h100, 64'h0, 32'h0, 32'h0, 0, 0, 1'b1);
      chk("pin_illegal", pin.trap, 2'b10);
      pin = model(6'b000011, 32'h400, 64'h0, 32'h0, 32'h0, 0, 0, 1'b0);
      chk("pin_ldd_nodw", pin.trap, 2'b10);
      pin = model(6'b000110, 32'h402, 64'hABCD, 32'h0, 32'h0, 0, 0, 1'b1);
      chk("pin_sth_be", pin.be[0], 4'b0011);
      chk("pin_sth_wd", pin.wd[0], 32'hABCDABCD);

      do_req(6'b001001, 32'h103, 64'h0, 32'h000000F0, 32'h0, 0, 0);        // LDSB
      do_req(6'b000010, 32'h200, 64'h0, 32'h80011234, 32'h0, 2, 0);        // LDUH, 2 waits
      do_req(6'b000111, 32'h308, 64'h11111111_22222222, 32'h0, 32'h0, 0, 1); // STD
      do_req(6'b000000, 32'h102, 64'h0, 32'h0, 32'h0, 0, 0);               // LD misaligned
      do_req(6'b111111, 32'h100, 64'h0, 32'h0, 32'h0, 0, 0);               // illegal
      do_req(6'b000011, 32'h410, 64'h0, 32'hCAFEBABE, 32'h01234567, 1, 0); // LDD
      do_req(6'b000110, 32'h402, 64'hABCD, 32'h0, 32'h0, 0, 0);            // STH
      do_req(6'b001010, 32'h206, 64'h0, 32'h00008123, 32'h0, 0, 0);        // LDSH neg
      do_req(6'b000001, 32'h101, 64'h0, 32'h00AB0000, 32'h0, 1, 0);        // LDUB
      do_req(6'b000101, 32'h503, 64'h5A, 32'h0, 32'h0, 0, 0);              // STB
      do_req(6'b000100, 32'h600, 64'hDEADBEEF, 32'h0, 32'h0, 3, 0);        // ST
      do_req(6'b000011, 32'h404, 64'h0, 32'h0, 32'h0, 0, 0);               // LDD misaligned
      do_req(6'b001001, 32'h100, 64'h0, 32'h7F000000, 32'h0, 0, 0);        // LDSB positive
      do_req(6'b001010, 32'h201, 64'h0, 32'h0, 32'h0, 0, 0);               // LDSH misaligned

      // Reset in the second LDD beat: access dropped, no response.
      chk_en = 1'b0; have_req = 1'b0;
      op3 = 6'b000011; addr = 32'h700; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("acc1_mem_en", mem_en, 1'b1);
      chk("acc1_mem_addr", mem_addr, 32'h704);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_en", mem_en, 1'b0);
      chk("midrst_req_ready", req_ready, 1'b1);
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_mem_be", mem_be, 4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("postrst_rsp_valid", rsp_valid, 1'b0);
         chk("postrst_mem_en", mem_en, 1'b0);
         chk("postrst_req_ready", req_ready, 1'b1);
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      do_req(6'b000000, 32'h800, 64'h0, 32'h0BADF00D, 32'h0, 0, 0);        // LD after reset

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
